// File: rtl/spi_mem_burst_if.sv
// Host-side request/stream signals and SPI RAM pins of spi_mem_burst.
// The slave modport is the engine's view; the master modport is the host/memory side.
interface spi_mem_burst_if #(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 4
);
   logic              start;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len;
   logic [7:0]        wr_data;
   logic              wr_req;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic              busy;
   logic              done;
   logic              cs_n;
   logic              sck;
   logic              mosi;
   logic              miso;

   modport master (
      output start, write, addr, len, wr_data, miso,
      input  wr_req, rd_data, rd_valid, busy, done, cs_n, sck, mosi
   );

   modport slave (
      input  start, write, addr, len, wr_data, miso,
      output wr_req, rd_data, rd_valid, busy, done, cs_n, sck, mosi
   );
endinterface

// File: rtl/spi_mem_burst.sv
// SPI mode-0 master for 23LC512-class serial RAM: command + address header
// followed by a read or write burst of len+1 bytes, byte-streamed to the host.
module spi_mem_burst #(
   parameter int ADDR_W  = 16,
   parameter int LEN_W   = 4,
   parameter int CLK_DIV = 1
) (
   input logic            clk,
   input logic            rst_n,
   spi_mem_burst_if.slave bus
);
   localparam int         SR_W   = 8 + ADDR_W;
   localparam int         BIT_W  = $clog2(SR_W);
   localparam int         DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [7:0] CMD_RD = 8'h03;
   localparam logic [7:0] CMD_WR = 8'h02;

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

   state_t            state, state_next;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [LEN_W-1:0]  byte_cnt;
   logic [SR_W-1:0]   tx_sr;
   logic [7:0]        rx_sr;
   logic              wr_mode;
   logic              sck_q, cs_n_q, busy_q, done_q, wr_req_q, rd_valid_q;
   logic [7:0]        rd_data_q;
   logic              accept, half_end, bit_end, last_bit, last_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      bit_end    = 1'b0;
      half_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
      last_bit   = (bit_cnt == '0);
      last_byte  = (byte_cnt == '0);
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = S_CMD;
            end
         end
         S_CMD: begin
            // a bit ends on the edge that closes its high phase
            bit_end = half_end & sck_q;
            if (bit_end && last_bit) state_next = S_DATA;
         end
         S_DATA: begin
            bit_end = half_end & sck_q;
            if (bit_end && last_bit && last_byte) state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_req_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
      end else begin
         done_q     <= 1'b0;
         wr_req_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cs_n_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  sck_q    <= 1'b0;
                  div_cnt  <= '0;
                  bit_cnt  <= BIT_W'(SR_W - 1);
                  byte_cnt <= bus.len;
               end
            end
            S_CMD, S_DATA: begin
               if (half_end) begin
                  div_cnt <= '0;
                  sck_q   <= ~sck_q;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
               if (bit_end) begin
                  if (!last_bit) begin
                     bit_cnt <= bit_cnt - BIT_W'(1);
                  end else begin
                     bit_cnt <= BIT_W'(7);
                     if (state == S_CMD) begin
                        wr_req_q <= wr_mode;
                     end else begin
                        if (!wr_mode) begin
                           rd_data_q  <= {rx_sr[6:0], bus.miso};
                           rd_valid_q <= 1'b1;
                        end
                        if (!last_byte) begin
                           byte_cnt <= byte_cnt - LEN_W'(1);
                           wr_req_q <= wr_mode;
                        end else begin
                           cs_n_q <= 1'b1;
                           busy_q <= 1'b0;
                           done_q <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Shift registers carry no reset; mosi is gated by state so they never leak out.
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_mode <= bus.write;
         tx_sr   <= {(bus.write ? CMD_WR : CMD_RD), bus.addr};
      end else if (bit_end) begin
         rx_sr <= {rx_sr[6:0], bus.miso};
         if (last_bit && (state == S_CMD || !last_byte))
            tx_sr <= {bus.wr_data, {ADDR_W{1'b0}}};
         else
            tx_sr <= {tx_sr[SR_W-2:0], 1'b0};
      end
   end

   assign bus.mosi     = ((state == S_CMD) || (state == S_DATA && wr_mode)) ? tx_sr[SR_W-1] : 1'b0;
   assign bus.sck      = sck_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.wr_req   = wr_req_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_spi_mem_burst.sv
// Directed bench for spi_mem_burst: three parameterisations, an SPI RAM slave model
// on the default instance, and hand-computed expectations for every step.
module tb_spi_mem_burst;
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   t0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_mem_burst_if #(.ADDR_W(16), .LEN_W(4)) if_a ();
   spi_mem_burst_if #(.ADDR_W(16), .LEN_W(4)) if_b ();
   spi_mem_burst_if #(.ADDR_W(24), .LEN_W(4)) if_c ();

   spi_mem_burst #(.ADDR_W(16), .LEN_W(4), .CLK_DIV(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   spi_mem_burst #(.ADDR_W(16), .LEN_W(4), .CLK_DIV(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   spi_mem_burst #(.ADDR_W(24), .LEN_W(4), .CLK_DIV(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

   assign if_b.miso = 1'b1;
   assign if_c.miso = 1'b1;

   // instance A: RAM slave model, mosi capture, event log
   int         nb_a = 0, sck_cnt_a = 0, done_cnt_a = 0, done_cyc_a = 0, busy_cnt_a = 0;
   int         rv_cnt_a = 0, wr_cnt_a = 0, wr_base_a = 0;
   logic       psck_a = 1'b0;
   logic       mbits_a [0:255];
   logic [7:0] slv_a [0:15];
   logic [7:0] wr_src_a [0:3];
   int         rv_cyc_a [0:63];
   logic [7:0] rv_dat_a [0:63];

   always @(negedge clk) begin : mon_a
      int k;
      if (if_a.cs_n) nb_a = 0;
      else begin
         if (if_a.sck && !psck_a) begin mbits_a[nb_a & 255] = if_a.mosi; sck_cnt_a++; end
         if (!if_a.sck && psck_a) nb_a++;
      end
      psck_a = if_a.sck;
      k = nb_a - 24;
      if_a.miso = (k >= 0 && k < 128) ? slv_a[k / 8][7 - (k % 8)] : 1'b0;
      if (if_a.done) begin done_cnt_a++; done_cyc_a = cyc; end
      if (if_a.busy) busy_cnt_a++;
      if (if_a.rd_valid) begin
         rv_cyc_a[rv_cnt_a & 63] = cyc;
         rv_dat_a[rv_cnt_a & 63] = if_a.rd_data;
         rv_cnt_a++;
      end
      if (if_a.wr_req) wr_cnt_a++;
      if_a.wr_data = wr_src_a[(wr_cnt_a - wr_base_a) & 3];
   end

   // instance B: SCK phase lengths
   int   done_cnt_b = 0, done_cyc_b = 0, run_b = 0;
   int   hi_min_b = 1000, hi_max_b = 0, lo_min_b = 1000, lo_max_b = 0;
   logic psck_b = 1'b0;

   always @(negedge clk) begin
      if (if_b.cs_n) run_b = 0;
      else if (run_b > 0 && if_b.sck != psck_b) begin
         if (psck_b) begin
            if (run_b < hi_min_b) hi_min_b = run_b;
            if (run_b > hi_max_b) hi_max_b = run_b;
         end else begin
            if (run_b < lo_min_b) lo_min_b = run_b;
            if (run_b > lo_max_b) lo_max_b = run_b;
         end
         run_b = 1;
      end else run_b++;
      psck_b = if_b.sck;
      if (if_b.done) begin done_cnt_b++; done_cyc_b = cyc; end
   end

   // instance C: mosi capture
   int   nb_c = 0, done_cnt_c = 0, done_cyc_c = 0;
   logic psck_c = 1'b0;
   logic mbits_c [0:255];

   always @(negedge clk) begin
      if (if_c.cs_n) nb_c = 0;
      else begin
         if (if_c.sck && !psck_c) mbits_c[nb_c & 255] = if_c.mosi;
         if (!if_c.sck && psck_c) nb_c++;
      end
      psck_c = if_c.sck;
      if (if_c.done) begin done_cnt_c++; done_cyc_c = cyc; end
   end

   function automatic logic [7:0] mbyte(input int which, input int j);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = (which == 0) ? mbits_a[8*j+i] : mbits_c[8*j+i];
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int which, input int base, input int budget);
      int n = 0;
      int cur = base;
      while (cur <= base && n < budget) begin
         @(negedge clk);
         n++;
         cur = (which == 0) ? done_cnt_a : (which == 1) ? done_cnt_b : done_cnt_c;
      end
      chk("done_within_budget", 32'(cur > base), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic start_a(input logic w, input logic [15:0] ad, input logic [3:0] ln);
      @(negedge clk);
      if_a.write = w; if_a.addr = ad; if_a.len = ln; if_a.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0;
      t0 = cyc;
   endtask

   int b_done, b_rv, b_wr, b_busy, b_sck;

   task automatic snap_a();
      b_done = done_cnt_a; b_rv = rv_cnt_a; b_wr = wr_cnt_a; b_busy = busy_cnt_a; b_sck = sck_cnt_a;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.start = 0; if_a.write = 0; if_a.addr = '0; if_a.len = '0;
      if_b.start = 0; if_b.write = 0; if_b.addr = '0; if_b.len = '0; if_b.wr_data = '0;
      if_c.start = 0; if_c.write = 0; if_c.addr = '0; if_c.len = '0; if_c.wr_data = '0;
      for (int i = 0; i < 16; i++) slv_a[i] = 8'h00;
      for (int i = 0; i < 4; i++) wr_src_a[i] = 8'h00;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cs_n", if_a.cs_n, 1);
      chk("rst_sck", if_a.sck, 0);
      chk("rst_mosi", if_a.mosi, 0);
      chk("rst_busy", if_a.busy, 0);
      chk("rst_done", if_a.done, 0);
      chk("rst_wr_req", if_a.wr_req, 0);
      chk("rst_rd_valid", if_a.rd_valid, 0);
      chk("rst_rd_data", if_a.rd_data, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single-byte read
      slv_a[0] = 8'hA5;
      snap_a();
      start_a(1'b0, 16'h1234, 4'd0);
      chk("rd1_busy_c1", if_a.busy, 1);
      chk("rd1_cs_n_c1", if_a.cs_n, 0);
      chk("rd1_sck_c1", if_a.sck, 0);
      wait_done(0, b_done, 200);
      chk("rd1_mosi0", mbyte(0, 0), 8'h03);
      chk("rd1_mosi1", mbyte(0, 1), 8'h12);
      chk("rd1_mosi2", mbyte(0, 2), 8'h34);
      chk("rd1_rd_data", if_a.rd_data, 8'hA5);
      chk("rd1_rv_count", rv_cnt_a - b_rv, 1);
      chk("rd1_rv_data", rv_dat_a[b_rv & 63], 8'hA5);
      chk("rd1_done_cycle", done_cyc_a - t0 + 1, 65);
      chk("rd1_busy_cycles", busy_cnt_a - b_busy, 64);
      chk("rd1_rv_with_done", rv_cyc_a[b_rv & 63], done_cyc_a);
      chk("rd1_cs_n_after", if_a.cs_n, 1);

      // burst read of four bytes
      slv_a[0] = 8'h11; slv_a[1] = 8'h22; slv_a[2] = 8'h33; slv_a[3] = 8'h44;
      snap_a();
      start_a(1'b0, 16'h0040, 4'd3);
      wait_done(0, b_done, 400);
      chk("brd_rv_count", rv_cnt_a - b_rv, 4);
      chk("brd_data0", rv_dat_a[(b_rv + 0) & 63], 8'h11);
      chk("brd_data1", rv_dat_a[(b_rv + 1) & 63], 8'h22);
      chk("brd_data2", rv_dat_a[(b_rv + 2) & 63], 8'h33);
      chk("brd_data3", rv_dat_a[(b_rv + 3) & 63], 8'h44);
      for (int i = 1; i < 4; i++)
         chk("brd_rv_spacing", rv_cyc_a[(b_rv + i) & 63] - rv_cyc_a[(b_rv + i - 1) & 63], 16);
      chk("brd_sck_count", sck_cnt_a - b_sck, 56);
      chk("brd_done_cycle", done_cyc_a - t0 + 1, 113);
      chk("brd_last_rv_with_done", rv_cyc_a[(b_rv + 3) & 63], done_cyc_a);

      // burst write of two bytes
      wr_src_a[0] = 8'hDE; wr_src_a[1] = 8'hAD; wr_src_a[2] = 8'h00; wr_src_a[3] = 8'h00;
      wr_base_a = wr_cnt_a;
      repeat (2) @(negedge clk);
      snap_a();
      start_a(1'b1, 16'h00FF, 4'd1);
      wait_done(0, b_done, 300);
      chk("wr_mosi0", mbyte(0, 0), 8'h02);
      chk("wr_mosi1", mbyte(0, 1), 8'h00);
      chk("wr_mosi2", mbyte(0, 2), 8'hFF);
      chk("wr_mosi3", mbyte(0, 3), 8'hDE);
      chk("wr_mosi4", mbyte(0, 4), 8'hAD);
      chk("wr_req_count", wr_cnt_a - b_wr, 2);
      chk("wr_rv_count", rv_cnt_a - b_rv, 0);
      chk("wr_done_cycle", done_cyc_a - t0 + 1, 81);

      // start while busy is ignored
      slv_a[0] = 8'h5A;
      snap_a();
      start_a(1'b0, 16'h1234, 4'd0);
      repeat (20) @(negedge clk);
      if_a.addr = 16'hBEEF; if_a.write = 1'b1; if_a.len = 4'd5; if_a.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0;
      wait_done(0, b_done, 200);
      chk("sb_mosi0", mbyte(0, 0), 8'h03);
      chk("sb_mosi1", mbyte(0, 1), 8'h12);
      chk("sb_mosi2", mbyte(0, 2), 8'h34);
      chk("sb_rd_data", if_a.rd_data, 8'h5A);
      chk("sb_wr_req_count", wr_cnt_a - b_wr, 0);
      chk("sb_done_cycle", done_cyc_a - t0 + 1, 65);
      repeat (100) @(negedge clk);
      chk("sb_single_done", done_cnt_a - b_done, 1);
      chk("sb_rv_count", rv_cnt_a - b_rv, 1);
      chk("sb_idle_busy", if_a.busy, 0);

      // asynchronous reset in the middle of the header
      if_a.write = 1'b0;
      snap_a();
      start_a(1'b0, 16'h1234, 4'd0);
      repeat (9) @(negedge clk);
      chk("rst_mid_sck_high", if_a.sck, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_cs_n", if_a.cs_n, 1);
      chk("rst_mid_sck", if_a.sck, 0);
      chk("rst_mid_busy", if_a.busy, 0);
      chk("rst_mid_mosi", if_a.mosi, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_mid_no_done", done_cnt_a - b_done, 0);
      chk("rst_mid_no_rv", rv_cnt_a - b_rv, 0);
      chk("rst_mid_cs_n_idle", if_a.cs_n, 1);

      // SCK divider of 3
      b_done = done_cnt_b;
      @(negedge clk);
      if_b.write = 1'b0; if_b.addr = 16'h1234; if_b.len = 4'd0; if_b.start = 1'b1;
      @(negedge clk);
      if_b.start = 1'b0;
      t0 = cyc;
      wait_done(1, b_done, 400);
      chk("div_done_cycle", done_cyc_b - t0 + 1, 193);
      chk("div_hi_min", hi_min_b, 3);
      chk("div_hi_max", hi_max_b, 3);
      chk("div_lo_min", lo_min_b, 3);
      chk("div_lo_max", lo_max_b, 3);
      chk("div_rd_data", if_b.rd_data, 8'hFF);

      // 24-bit address read
      b_done = done_cnt_c;
      @(negedge clk);
      if_c.write = 1'b0; if_c.addr = 24'h012345; if_c.len = 4'd0; if_c.start = 1'b1;
      @(negedge clk);
      if_c.start = 1'b0;
      t0 = cyc;
      wait_done(2, b_done, 200);
      chk("a24_mosi0", mbyte(2, 0), 8'h03);
      chk("a24_mosi1", mbyte(2, 1), 8'h01);
      chk("a24_mosi2", mbyte(2, 2), 8'h23);
      chk("a24_mosi3", mbyte(2, 3), 8'h45);
      chk("a24_done_cycle", done_cyc_c - t0 + 1, 81);
      chk("a24_rd_data", if_c.rd_data, 8'hFF);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/spi_mem_burst.md
# spi_mem_burst

Parametrised SPI master for 23LC512-class serial RAM. It supports both read (0x03) and write (0x02) with multi-byte sequential bursts, a configurable address width and a programmable SCK divider. It sits between the CPU memory-access logic and the external SPI RAM pins, and supersedes the single-byte read engine. Data moves one byte at a time:
- read bytes stream out on `rd_data`/`rd_valid`;
- write bytes are pulled from `wr_data` via `wr_req`.

## Interface
- `ADDR_W`, default 16: address width in bits. Must be a multiple of 8, range 8..24. The address is sent as ADDR_W/8 bytes, MSB first.
- `LEN_W`, default 4: width of `len`. The maximum burst is 2^LEN_W bytes.
- `CLK_DIV`, default 1: `clk` cycles per SCK half-period. Must be ≥1.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: transaction request. Sampled only in IDLE; ignored otherwise.
- `write` in 1: selects the command, latched with `start`. 1 = write (0x02), 0 = read (0x03).
- `addr` in ADDR_W: start address, latched with `start`.
- `len` in LEN_W: byte count minus 1, latched with `start`.
- `wr_data` in 8: next write byte. Must be valid before it is captured.
- `wr_req` out 1: one-cycle pulse. Indicates `wr_data` was captured; the host presents the next byte.
- `rd_data` out 8: last received byte.
- `rd_valid` out 1: one-cycle pulse when `rd_data` is updated.
- `busy` out 1: high from the accepting edge until DONE.
- `done` out 1: one-cycle pulse at the end of the transaction.
- `cs_n` out 1: chip select, active low.
- `sck` out 1: SPI clock, mode 0 (idle low).
- `mosi` out 1: master out.
- `miso` in 1: master in.

## Operation
- States: IDLE → CMD → DATA → DONE → IDLE.
- **IDLE:** `cs_n`=1, `sck`=0, `busy`=0.
  - On `start`=1, latch `write`, `addr` and `len`.
  - Load the shifter with {cmd, addr}.
  - Set `cs_n`=0 and `busy`=1, then go to CMD.
- **Bit timing (CMD and DATA):**
  - Low phase: CLK_DIV cycles with `sck`=0. `mosi` is updated on the edge that starts the low phase.
  - High phase: CLK_DIV cycles with `sck`=1.
  - `miso` is sampled on the edge that ends the high phase; that same edge starts the next low phase.
  - Bits are transferred MSB first.
- **CMD:** 8+ADDR_W bits.
  - For writes, the edge ending the last CMD bit captures `wr_data` into the shifter. `wr_req`=1 in the following cycle.
  - CMD then transitions to DATA.
- **DATA:** 8·(len+1) bits.
  - Write: the edge ending bit 0 of each non-final byte captures the next `wr_data` and pulses `wr_req`. There are exactly len+1 `wr_req` pulses in total. `mosi` carries the write data.
  - Read: `mosi`=0. The edge ending bit 0 of each byte loads `rd_data` with the assembled byte, and `rd_valid`=1 in the next cycle. There are exactly len+1 `rd_valid` pulses.
- **DONE:** lasts one cycle, with `cs_n`=1, `sck`=0, `busy`=0 and `done`=1. A `start` is accepted no earlier than the following (IDLE) cycle.
- **Counters:** the bit counter is sized for 8+ADDR_W. The byte counter is LEN_W wide, counts down from `len`, and does not wrap.
- **Reset mid-transaction:** all outputs return immediately to their reset values and the state returns to IDLE. No partial `done` or `rd_valid` is produced.
- `start` while busy is ignored, with no effect on the latched fields.

## Timing
- Reset values: `cs_n`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `wr_req`=0, `rd_valid`=0, `rd_data`=0x00.
- Let NB = 8·(1 + ADDR_W/8 + len + 1). `done` asserts 2·CLK_DIV·NB + 1 cycles after the `start`-accepting edge.
- Default parameters with len=0 give 65 cycles.
- For reads, the final `rd_valid` coincides with `done`.
- `cs_n` falls on the accepting edge, before the first SCK rise, which is CLK_DIV cycles later. `cs_n` rises in DONE, after the last SCK fall.
- `wr_data` must be stable at each capture edge. The host has ≥16·CLK_DIV−1 cycles after a `wr_req` to present the next byte.

## Test plan
- **Single-byte read:** ADDR_W=16, CLK_DIV=1, read, `addr`=0x1234, `len`=0, slave model returns 0xA5.
  - `mosi` bytes 03 12 34.
  - `rd_data`=0xA5 with one `rd_valid`.
  - `done` at cycle 65; `busy` high for cycles 1..64.
- **Burst read:** `len`=3, slave returns 11 22 33 44.
  - Four `rd_valid` pulses, 16 cycles apart, carrying 0x11, 0x22, 0x33, 0x44.
  - SCK count = 56.
- **Burst write:** `write`=1, `addr`=0x00FF, `len`=1, host supplies DE then AD.
  - `mosi` bytes 02 00 FF DE AD.
  - Exactly two `wr_req` pulses; `rd_valid` stays 0.
- **Divider:** CLK_DIV=3, single-byte read.
  - SCK high and low phases each exactly 3 cycles.
  - `done` at cycle 193.
- **Start while busy:** pulse `start` with `addr`=0xBEEF in the middle of a transaction.
  - The current transfer is unchanged and no second transaction starts.
  - After a reset pulse mid-CMD, `cs_n`=1 and `sck`=0 immediately (asynchronously), with no `done`.
- **ADDR_W=24:** read of `addr`=0x012345.
  - `mosi` bytes 03 01 23 45.
  - `done` at cycle 81.
